// File: rtl/nonce_result_tx.sv
// nonce_result_tx
// Collects winning nonces reported by HASHERS hasher cores, queues them in a
// FIFO and sends each one to the host byte link as a 10-byte frame:
//   SYNC_BYTE, nonce byte 0 .. byte 7 (little-endian), XOR of the 8 nonce bytes.
// The miner software resynchronises on SYNC_BYTE and applies the full target check.
//
// Ports:
//   clk, nRst       - clock, asynchronous active-low reset
//   GoodNonceFound  - per-core single-cycle found strobe
//   NonceIn         - per-core nonce, core i at [64*i +: 64], valid with its strobe
//   FlushReq        - discards every buffered result whose frame has not started
//   TxData, TxValid - byte toward the host link, held stable until accepted
//   TxReady         - host link accepts the presented byte
//   FifoLevel       - current FIFO occupancy
//   DropCount       - saturating count of results lost to holding-register collisions
module nonce_result_tx #(
    parameter int         HASHERS    = 1,
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] SYNC_BYTE  = 8'hAA
) (
    input  logic                        clk,
    input  logic                        nRst,
    input  logic [HASHERS-1:0]          GoodNonceFound,
    input  logic [64*HASHERS-1:0]       NonceIn,
    input  logic                        FlushReq,
    output logic [7:0]                  TxData,
    output logic                        TxValid,
    input  logic                        TxReady,
    output logic [$clog2(FIFO_DEPTH):0] FifoLevel,
    output logic [15:0]                 DropCount
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LVL_W = AW + 1;
    // A single core still needs a one-bit arbiter index
    localparam int IW    = (HASHERS > 1) ? $clog2(HASHERS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SYNC = 2'd1,
        S_DATA = 2'd2,
        S_CSUM = 2'd3
    } state_e;

    // Holding registers and arbitration
    logic [HASHERS-1:0]       pend_q, pend_d;
    logic [HASHERS-1:0][63:0] hold_q;
    logic [HASHERS-1:0]       cap_s;
    logic [HASHERS-1:0]       drop_s;
    logic [IW-1:0]            rr_q, rr_d;
    logic [IW-1:0]            win_s;
    logic                     any_pend_s;
    logic                     push_s;
    logic                     pop_s;

    // Drop counter
    logic [15:0] drop_q, drop_d;
    logic [4:0]  drop_cnt_s;
    logic [16:0] drop_sum_s;

    // FIFO
    logic [63:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [LVL_W-1:0] cnt_q;
    logic             full_s, empty_s;

    // Transmit FSM
    state_e      state_q;
    logic [63:0] shift_q;
    logic [7:0]  csum_q;
    logic [2:0]  idx_q;
    logic [7:0]  tx_data_q;
    logic        tx_valid_q;

    assign full_s  = (cnt_q == LVL_W'(FIFO_DEPTH));
    assign empty_s = (cnt_q == '0);

    // A flush discards the push of this edge; a pop needs data and an idle transmitter
    assign push_s = any_pend_s && !full_s && !FlushReq;
    assign pop_s  = (state_q == S_IDLE) && !empty_s && !FlushReq;

    // Round-robin search: nearest pending core at or after the pointer wins
    always_comb begin : rr_search
        int idx;
        idx        = 0;
        win_s      = '0;
        any_pend_s = 1'b0;
        // Walk from farthest to nearest so the nearest pending core is written last
        for (int off = HASHERS - 1; off >= 0; off--) begin
            idx = int'(rr_q) + off;
            if (idx >= HASHERS) begin
                idx = idx - HASHERS;
            end else begin
                idx = idx;
            end
            if (pend_q[idx]) begin
                win_s      = IW'(idx);
                any_pend_s = 1'b1;
            end else begin
                any_pend_s = any_pend_s;
            end
        end
    end

    // Pointer moves past the winner after every push
    always_comb begin
        if (push_s) begin
            if (win_s == IW'(HASHERS - 1)) begin
                rr_d = '0;
            end else begin
                rr_d = win_s + IW'(1);
            end
        end else begin
            rr_d = rr_q;
        end
    end

    // Per-core holding register update: capture, clear on push, collision detect
    always_comb begin
        pend_d = pend_q;
        cap_s  = '0;
        drop_s = '0;
        for (int i = 0; i < HASHERS; i++) begin
            if (FlushReq) begin
                pend_d[i] = 1'b0;
            end else if (GoodNonceFound[i]) begin
                // A push out of this register on the same edge frees it for the new nonce
                if (pend_q[i] && !(push_s && (win_s == IW'(i)))) begin
                    drop_s[i] = 1'b1;
                end else begin
                    cap_s[i]  = 1'b1;
                    pend_d[i] = 1'b1;
                end
            end else if (push_s && (win_s == IW'(i))) begin
                pend_d[i] = 1'b0;
            end else begin
                pend_d[i] = pend_q[i];
            end
        end
    end

    // Saturating add of the number of cores that lost a result this edge
    always_comb begin
        drop_cnt_s = 5'd0;
        for (int i = 0; i < HASHERS; i++) begin
            drop_cnt_s = drop_cnt_s + 5'(drop_s[i]);
        end
        drop_sum_s = {1'b0, drop_q} + {12'd0, drop_cnt_s};
        if (drop_sum_s[16]) begin
            drop_d = 16'hFFFF;
        end else begin
            drop_d = drop_sum_s[15:0];
        end
    end

    // Holding registers, arbiter pointer and drop counter
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            pend_q <= '0;
            hold_q <= '0;
            rr_q   <= '0;
            drop_q <= 16'd0;
        end else begin
            pend_q <= pend_d;
            rr_q   <= rr_d;
            drop_q <= drop_d;
            for (int i = 0; i < HASHERS; i++) begin
                if (cap_s[i]) begin
                    hold_q[i] <= NonceIn[64*i +: 64];
                end
            end
        end
    end

    // Result FIFO storage and pointers; level is unchanged on simultaneous push and pop
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 64'd0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (FlushReq) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_s) begin
                mem_q[wr_q] <= hold_q[win_s];
                wr_q        <= wr_q + AW'(1);
            end
            if (pop_s) begin
                rd_q <= rd_q + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   cnt_q <= cnt_q + LVL_W'(1);
                2'b01:   cnt_q <= cnt_q - LVL_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Frame transmitter; TxValid stays high from SYNC through CSUM, so a handshake is TxReady
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q    <= S_IDLE;
            shift_q    <= 64'd0;
            csum_q     <= 8'd0;
            idx_q      <= 3'd0;
            tx_data_q  <= 8'd0;
            tx_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop_s) begin
                        shift_q    <= mem_q[rd_q];
                        csum_q     <= 8'd0;
                        tx_data_q  <= SYNC_BYTE;
                        tx_valid_q <= 1'b1;
                        state_q    <= S_SYNC;
                    end
                end
                S_SYNC: begin
                    if (TxReady) begin
                        idx_q     <= 3'd0;
                        tx_data_q <= shift_q[7:0];
                        state_q   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (TxReady) begin
                        csum_q  <= csum_q ^ shift_q[7:0];
                        shift_q <= {8'd0, shift_q[63:8]};
                        idx_q   <= idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            // Last nonce byte accepted: present the finished checksum
                            tx_data_q <= csum_q ^ shift_q[7:0];
                            state_q   <= S_CSUM;
                        end else begin
                            tx_data_q <= shift_q[15:8];
                        end
                    end
                end
                S_CSUM: begin
                    if (TxReady) begin
                        tx_data_q  <= 8'd0;
                        tx_valid_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                default: begin
                    tx_data_q  <= 8'd0;
                    tx_valid_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign TxData    = tx_data_q;
    assign TxValid   = tx_valid_q;
    assign FifoLevel = cnt_q;
    assign DropCount = drop_q;

endmodule
